parking_slot_allocator: RTL
===========================

// Module: parking_slot_allocator
// PURPOSE
// - Upstream of the occupancy 7-segment display stage. Produces the 8-bit per-slot occupancy vector that stage counts and displays.
// - Turns raw entry/exit push-buttons into slot allocations and releases.
// - Allocates the lowest free slot on entry and frees the operator-selected slot on exit.
// - Sequences timed entry/exit gate-open pulses and flags full and rejected requests.
// PARAMETERS
// - N_SLOTS           8           number of parking slots; width of slots[]
// - GATE_OPEN_CYCLES  100000000   clk cycles a gate stays open (1 s at 100 MHz)
// PORTS
// - clk            in   1                  system clock; single clock domain, all flops rising-edge
// - rst_n          in   1                  asynchronous, active-low reset
// - entry_btn      in   1                  raw entry request, asynchronous to clk
// - exit_btn       in   1                  raw exit request, asynchronous to clk
// - exit_slot      in   $clog2(N_SLOTS)    index of the slot being vacated; sampled on the exit edge
// - slots          out  N_SLOTS            occupancy vector, 1 = occupied; feeds the display stage
// - full           out  1                  registered; equals &slots
// - gate_in_open   out  1                  entry gate drive
// - gate_out_open  out  1                  exit gate drive
// - last_slot      out  $clog2(N_SLOTS)    slot index most recently allocated or freed
// - reject         out  1                  1-cycle pulse: entry while full, or exit of a free slot
// BEHAVIOUR
// - Reset (async, rst_n=0): slots=0, full=0, gate_in_open=0, gate_out_open=0, last_slot=0, reject=0, state=IDLE, both pending flags=0, timer=0, sync flops=0. Outputs clear immediately, without waiting for clk.
// - Input path: each button goes through 2-FF sync, then a registered rising-edge detect.
// - Latency: the state/outputs update on the 3rd rising clk edge after the first edge that samples the button high.
// - A held button produces exactly one request.
// - FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN.
// - IDLE with exit request (live edge or pending_exit):
//   - If slots[exit_slot]=1: clear that bit, last_slot<=exit_slot, gate_out_open<=1, timer<=GATE_OPEN_CYCLES-1, go to EXIT_OPEN.
//   - If slots[exit_slot]=0: reject=1 for one cycle, stay IDLE, slots unchanged.
// - IDLE with entry request (live or pending_entry) and no exit request:
//   - If !full: set the lowest-index 0 bit of slots, last_slot<=that index, gate_in_open<=1, timer<=GATE_OPEN_CYCLES-1, go to ENTRY_OPEN.
//   - If full: reject=1 for one cycle, stay IDLE.
// - Simultaneous entry and exit in IDLE: exit is served first; entry is latched into pending_entry.
// - ENTRY_OPEN / EXIT_OPEN:
//   - timer decrements once per cycle.
//   - On timer==0, drop the gate output and return to IDLE (gate high exactly GATE_OPEN_CYCLES cycles).
//   - Edges arriving here set pending_entry / pending_exit; these flags are one-deep.
//   - Further edges of the same type while pending are dropped silently.
//   - exit_slot is re-sampled when a pending exit is served.
// - Pending requests are served in the first IDLE cycle, exit first. Clear the flag when served or rejected.
// - Widths: timer is $clog2(GATE_OPEN_CYCLES+1) bits; index is $clog2(N_SLOTS) bits. exit_slot >= N_SLOTS is treated as a free slot and rejected.
// - full is updated in the same cycle as slots. Only one slot changes per cycle.
// - reject never coincides with a gate rising edge.
// STRUCTURE
// - Package parking_pkg holds:
//   - state enum {IDLE, ENTRY_OPEN, EXIT_OPEN}
//   - N_SLOTS default and SLOT_W = $clog2(N_SLOTS)
//   - function lowest_free(slots) -> index (priority encoder)
// - One sub-module, btn_sync_edge (2-FF synchronizer + rising-edge pulse, async active-low reset), instantiated twice.
// - Allocation, release, FSM and timer stay in this module.
// TESTING (bench uses GATE_OPEN_CYCLES=4)
// - Reset, then 8 separated entry presses -> slots 0x01,0x03,0x07,...,0xFF; last_slot 0..7; full=1 after the 8th; each gate_in_open exactly 4 cycles.
// - slots=0xFF, entry press -> reject one cycle, slots stays 0xFF, gate_in_open stays 0.
// - slots=0xFF, exit with exit_slot=3 -> slots=0xF7, full=0, gate_out_open 4 cycles. Next entry -> slots=0xFF, last_slot=3.
// - slots=0x01, exit with exit_slot=5 -> reject pulse, slots unchanged, no gate activity.
// - slots=0xFF, entry and exit (exit_slot=6) same cycle -> slots=0xBF, EXIT_OPEN 4 cycles, then ENTRY_OPEN, slots=0xFF, last_slot=6.
// - rst_n low mid ENTRY_OPEN, between clk edges -> all outputs 0 immediately. After release, IDLE with no stale pending request served.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared FSM state type, slot-count defaults and the lowest-free-slot priority
// encoder used by the parking slot allocator.
package parking_pkg;

  localparam int N_SLOTS_DEFAULT = 8;
  localparam int SLOT_W          = $clog2(N_SLOTS_DEFAULT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2
  } state_e;

  // Index of the lowest-numbered free (0) slot; 0 when every slot is taken,
  // which the caller never uses because a full lot rejects the entry.
  function automatic logic [SLOT_W-1:0] lowest_free(
    input logic [N_SLOTS_DEFAULT-1:0] slots
  );
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int i = N_SLOTS_DEFAULT - 1; i >= 0; i--) begin
      if (!slots[i]) idx = SLOT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/parking_slot_allocator_btn_sync_edge.sv
// Two-flop synchronizer for a raw push-button followed by a registered
// rising-edge detector; a held button yields a single one-cycle pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;
  logic r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_meta   <= i_btn;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      r_pulse  <= r_sync & ~r_sync_d;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/parking_slot_allocator.sv
// Parking lot slot allocator: turns entry/exit button presses into slot
// allocations/releases, drives timed gate pulses and flags rejected requests.
module parking_slot_allocator
  import parking_pkg::*;
#(
  parameter int N_SLOTS          = N_SLOTS_DEFAULT,
  parameter int GATE_OPEN_CYCLES = 100000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       entry_btn,
  input  logic                       exit_btn,
  input  logic [$clog2(N_SLOTS)-1:0] exit_slot,
  output logic [N_SLOTS-1:0]         slots,
  output logic                       full,
  output logic                       gate_in_open,
  output logic                       gate_out_open,
  output logic [$clog2(N_SLOTS)-1:0] last_slot,
  output logic                       reject,
  output state_e                     dbg_state
);

  localparam int IDX_W   = $clog2(N_SLOTS);
  localparam int TIMER_W = $clog2(GATE_OPEN_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(GATE_OPEN_CYCLES - 1);

  // Request pulses: each is a single-cycle strobe with no ready/back-pressure;
  // a strobe that cannot be served at once is parked in a one-deep pending flag.
  logic w_entry_edge;
  logic w_exit_edge;

  btn_sync_edge u_entry_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (entry_btn),
    .o_pulse (w_entry_edge)
  );

  btn_sync_edge u_exit_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (exit_btn),
    .o_pulse (w_exit_edge)
  );

  state_e               r_state;
  logic [N_SLOTS-1:0]   r_slots;
  logic                 r_full;
  logic                 r_gate_in;
  logic                 r_gate_out;
  logic [IDX_W-1:0]     r_last;
  logic                 r_reject;
  logic                 r_pend_entry;
  logic                 r_pend_exit;
  logic [TIMER_W-1:0]   r_timer;

  state_e               w_state;
  logic [N_SLOTS-1:0]   w_slots;
  logic                 w_gate_in;
  logic                 w_gate_out;
  logic [IDX_W-1:0]     w_last;
  logic                 w_reject;
  logic                 w_pend_entry;
  logic                 w_pend_exit;
  logic [TIMER_W-1:0]   w_timer;

  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_exit_ok;

  assign w_free_idx = lowest_free(r_slots);
  // Out-of-range indices behave like a free slot and are rejected.
  assign w_exit_ok  = (int'(exit_slot) < N_SLOTS) && r_slots[exit_slot];

  always_comb begin
    w_state      = r_state;
    w_slots      = r_slots;
    w_gate_in    = r_gate_in;
    w_gate_out   = r_gate_out;
    w_last       = r_last;
    w_reject     = 1'b0;
    w_timer      = r_timer;
    w_pend_entry = r_pend_entry | w_entry_edge;
    w_pend_exit  = r_pend_exit  | w_exit_edge;

    case (r_state)
      IDLE: begin
        // Exit wins a tie; an entry seen in the same cycle stays pending.
        if (w_pend_exit) begin
          w_pend_exit = 1'b0;
          if (w_exit_ok) begin
            w_slots[exit_slot] = 1'b0;
            w_last             = exit_slot;
            w_gate_out         = 1'b1;
            w_timer            = TIMER_LOAD;
            w_state            = EXIT_OPEN;
          end else begin
            w_reject = 1'b1;
          end
        end else if (w_pend_entry) begin
          w_pend_entry = 1'b0;
          if (!r_full) begin
            w_slots[w_free_idx] = 1'b1;
            w_last              = w_free_idx;
            w_gate_in           = 1'b1;
            w_timer             = TIMER_LOAD;
            w_state             = ENTRY_OPEN;
          end else begin
            w_reject = 1'b1;
          end
        end
      end

      ENTRY_OPEN: begin
        if (r_timer == '0) begin
          w_gate_in = 1'b0;
          w_state   = IDLE;
        end else begin
          w_timer = r_timer - 1'b1;
        end
      end

      EXIT_OPEN: begin
        if (r_timer == '0) begin
          w_gate_out = 1'b0;
          w_state    = IDLE;
        end else begin
          w_timer = r_timer - 1'b1;
        end
      end

      default: begin
        w_gate_in  = 1'b0;
        w_gate_out = 1'b0;
        w_state    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_slots      <= '0;
      r_full       <= 1'b0;
      r_gate_in    <= 1'b0;
      r_gate_out   <= 1'b0;
      r_last       <= '0;
      r_reject     <= 1'b0;
      r_pend_entry <= 1'b0;
      r_pend_exit  <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_state      <= w_state;
      r_slots      <= w_slots;
      r_full       <= &w_slots;
      r_gate_in    <= w_gate_in;
      r_gate_out   <= w_gate_out;
      r_last       <= w_last;
      r_reject     <= w_reject;
      r_pend_entry <= w_pend_entry;
      r_pend_exit  <= w_pend_exit;
      r_timer      <= w_timer;
    end
  end

  assign slots         = r_slots;
  assign full          = r_full;
  assign gate_in_open  = r_gate_in;
  assign gate_out_open = r_gate_out;
  assign last_slot     = r_last;
  assign reject        = r_reject;
  assign dbg_state     = r_state;

endmodule
